// File: rtl/hazard_stall_controller_pkg.sv
// Shared constants and FSM state encoding for the decode-stage hazard/stall controller.
package hazard_stall_controller_pkg;

    localparam int REG_ADDRESS_LEN = 4;
    localparam int MUL_CYCLES_DEF  = 4;

    typedef enum logic {
        HSC_IDLE     = 1'b0,
        HSC_MUL_BUSY = 1'b1
    } hsc_state_e;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_mul_stall_fsm.sv
// Multiply stall sequencer: state, countdown, re-trigger guard and deferred flush.
module mul_stall_fsm
    import hazard_stall_controller_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_exe_is_mul,
    input  logic i_flush_in,
    output logic o_mul_busy,
    output logic o_mul_done,
    output logic o_flush_pend
);

    localparam int               CNT_W    = cnt_width(MUL_CYCLES);
    localparam bit               MUL_EN   = (MUL_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hsc_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul_seen;
    logic             r_flush_pend;
    logic             r_mul_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= HSC_IDLE;
            r_cnt        <= '0;
            r_mul_seen   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_mul_done   <= 1'b0;
        end else begin
            r_mul_seen <= 1'b0;
            r_mul_done <= 1'b0;
            case (r_state)
                HSC_IDLE: begin
                    // Any pending flush is consumed by this IDLE cycle.
                    r_flush_pend <= 1'b0;
                    if (MUL_EN && i_exe_is_mul && !r_mul_seen) begin
                        r_state    <= HSC_MUL_BUSY;
                        r_cnt      <= CNT_LOAD;
                        r_mul_done <= (CNT_LOAD == '0);
                    end
                end
                HSC_MUL_BUSY: begin
                    if (i_flush_in) r_flush_pend <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state    <= HSC_IDLE;
                        r_mul_seen <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt - CNT_ONE;
                        r_mul_done <= (r_cnt == CNT_ONE);
                    end
                end
                default: r_state <= HSC_IDLE;
            endcase
        end
    end

    assign o_mul_busy   = (r_state == HSC_MUL_BUSY);
    assign o_mul_done   = r_mul_done;
    assign o_flush_pend = r_flush_pend;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage RAW hazard detection, multiply stall and flush sequencing.
// Define FORWARDING_EN to restrict the data hazard to EX load-use only.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int REG_ADDR_W = REG_ADDRESS_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_ignore_hazard,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic                  exe_is_mul,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  flush_in,
    output logic                  pc_freeze,
    output logic                  id_bubble,
    output logic                  ex_hold,
    output logic                  mem_bubble,
    output logic                  flush_out,
    output logic                  mul_busy,
    output logic                  mul_done
);

    logic w_busy;
    logic w_done;
    logic w_flush_pend;
    logic w_m1;
    logic w_m2;
    logic w_hz;
    logic w_flush;
    logic w_unused;

    mul_stall_fsm #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_exe_is_mul (exe_is_mul),
        .i_flush_in   (flush_in),
        .o_mul_busy   (w_busy),
        .o_mul_done   (w_done),
        .o_flush_pend (w_flush_pend)
    );

`ifdef FORWARDING_EN
    // EX results are forwarded; only a load in EX cannot satisfy a dependent read.
    assign w_m1     = exe_wb_en & exe_mem_read & (exe_dest == id_src1);
    assign w_m2     = exe_wb_en & exe_mem_read & (exe_dest == id_src2);
    assign w_unused = &{1'b0, mem_dest, mem_wb_en};
`else
    assign w_m1     = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1));
    assign w_m2     = (exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2));
    assign w_unused = &{1'b0, exe_mem_read};
`endif

    assign w_hz    = ~id_ignore_hazard & (w_m1 | (id_two_src & w_m2));
    assign w_flush = flush_in | w_flush_pend;

    // Outputs are gated by reset so the combinational paths are also quiet in reset.
    assign pc_freeze  = rst & (w_busy | (~w_flush & w_hz));
    assign id_bubble  = rst & ~w_busy & ~w_flush & w_hz;
    assign ex_hold    = rst & w_busy;
    assign mem_bubble = rst & w_busy;
    assign flush_out  = rst & ~w_busy & w_flush;
    assign mul_busy   = rst & w_busy;
    assign mul_done   = rst & w_done;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed literal checks plus randomized run vs. a behavioural model.
module tb_hazard_stall_controller;

    localparam int MC = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic          id_two_src = 1'b0, id_ignore_hazard = 1'b0;
    logic          exe_wb_en = 1'b0, exe_mem_read = 1'b0, exe_is_mul = 1'b0;
    logic          mem_wb_en = 1'b0, flush_in = 1'b0;
    logic          pc_freeze, id_bubble, ex_hold, mem_bubble, flush_out, mul_busy, mul_done;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_stall_controller #(
        .MUL_CYCLES (MC),
        .REG_ADDR_W (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .id_ignore_hazard (id_ignore_hazard),
        .exe_dest         (exe_dest),
        .exe_wb_en        (exe_wb_en),
        .exe_mem_read     (exe_mem_read),
        .exe_is_mul       (exe_is_mul),
        .mem_dest         (mem_dest),
        .mem_wb_en        (mem_wb_en),
        .flush_in         (flush_in),
        .pc_freeze        (pc_freeze),
        .id_bubble        (id_bubble),
        .ex_hold          (ex_hold),
        .mem_bubble       (mem_bubble),
        .flush_out        (flush_out),
        .mul_busy         (mul_busy),
        .mul_done         (mul_done)
    );

    always #5 clk = ~clk;

    // Output vector order: {pc_freeze, id_bubble, ex_hold, mem_bubble, flush_out, mul_busy, mul_done}
    function automatic logic [6:0] outs();
        return {pc_freeze, id_bubble, ex_hold, mem_bubble, flush_out, mul_busy, mul_done};
    endfunction

    // ---------------- behavioural model ----------------
    int m_left  = 0;   // stall cycles still to run with the MUL held in EX
    bit m_fresh = 0;   // first IDLE cycle after a stall: same MUL must not re-trigger
    bit m_pend  = 0;   // flush requested during the stall

    function automatic bit f_match(input logic [AW-1:0] s);
`ifdef FORWARDING_EN
        return exe_wb_en && exe_mem_read && (exe_dest == s);
`else
        return (exe_wb_en && (exe_dest == s)) || (mem_wb_en && (mem_dest == s));
`endif
    endfunction

    function automatic logic [6:0] model_outs();
        bit busy, fl, hz;
        if (!rst) return 7'b0;
        busy = (m_left > 0);
        fl   = !busy && (flush_in || m_pend);
        hz   = !id_ignore_hazard && (f_match(id_src1) || (id_two_src && f_match(id_src2)));
        return {busy || (!fl && hz), !busy && !fl && hz, busy, busy, fl, busy, busy && (m_left == 1)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left  <= 0;
            m_fresh <= 1'b0;
            m_pend  <= 1'b0;
        end else if (m_left > 0) begin
            m_pend  <= m_pend | flush_in;
            m_left  <= m_left - 1;
            m_fresh <= (m_left == 1);
        end else begin
            m_pend  <= 1'b0;
            m_fresh <= 1'b0;
            if (exe_is_mul && !m_fresh && MC > 1) m_left <= MC - 1;
        end
    end

    // Every-cycle compare, half a period away from the active edge.
    always @(negedge clk) begin
        logic [6:0] exp_v;
        exp_v = model_outs();
        n_chk++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: dut=%b model=%b", $time, outs(), exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [6:0] exp_v);
        n_chk++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, outs(), exp_v);
        end
    endtask

    task automatic clr();
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
        id_two_src = 0; id_ignore_hazard = 0; exe_wb_en = 0; exe_mem_read = 0;
        exe_is_mul = 0; mem_wb_en = 0; flush_in = 0;
    endtask

    task automatic rand_inputs(input bit with_mul);
        id_src1 = AW'($urandom_range(3));  id_src2 = AW'($urandom_range(3));
        exe_dest = AW'($urandom_range(3)); mem_dest = AW'($urandom_range(3));
        id_two_src = 1'($urandom_range(1));
        id_ignore_hazard = ($urandom_range(7) == 0);
        exe_wb_en = 1'($urandom_range(1)); exe_mem_read = 1'($urandom_range(1));
        mem_wb_en = 1'($urandom_range(1));
        exe_is_mul = with_mul && ($urandom_range(4) == 0);
        flush_in = ($urandom_range(9) == 0);
    endtask

    localparam logic [6:0] BUSY_V = 7'b1011010;
    localparam logic [6:0] DONE_V = 7'b1011011;
    localparam logic [6:0] HZ_V   = 7'b1100000;
    localparam logic [6:0] FL_V   = 7'b0000100;

    initial begin
        // Reset held with inputs toggling: every output must stay low.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            rand_inputs(1'b1);
            #2 check("reset_quiet", 7'b0);
        end
        next_cycle();
        clr();
        rst = 1'b1;
        #2 check("after_release", 7'b0);

`ifndef FORWARDING_EN
        next_cycle();
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1;
        #2 check("ex_raw_src1", HZ_V);
        next_cycle();
        id_ignore_hazard = 1;
        #2 check("ignore_hazard", 7'b0);
        next_cycle();
        clr();
        id_src2 = 4'd7; id_two_src = 1; mem_dest = 4'd7; mem_wb_en = 1;
        #2 check("mem_raw_src2", HZ_V);
        next_cycle();
        id_two_src = 0;
        #2 check("src2_unused", 7'b0);
`else
        next_cycle();
        exe_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1; exe_wb_en = 1;
        #2 check("fwd_no_load", 7'b0);
        next_cycle();
        exe_mem_read = 1;
        #2 check("fwd_load_use", HZ_V);
        next_cycle();
        exe_mem_read = 0; exe_wb_en = 0; mem_dest = 4'd5; mem_wb_en = 1;
        #2 check("fwd_mem_only", 7'b0);
`endif

        // Flush in IDLE overrides a live hazard.
        next_cycle();
        clr();
        id_src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1; flush_in = 1;
        #2 check("idle_flush_over_hz", FL_V);

        // Multiply held in EX: three stall cycles, done on the last, no re-trigger.
        next_cycle();
        clr();
        exe_is_mul = 1;
        #2 check("mul_entry_idle", 7'b0);
        next_cycle(); #2 check("mul_busy_1", BUSY_V);
        next_cycle(); #2 check("mul_busy_2", BUSY_V);
        next_cycle(); #2 check("mul_busy_3_done", DONE_V);
        next_cycle(); #2 check("mul_no_retrigger", 7'b0);
        next_cycle();
        exe_is_mul = 0;

        // Flush arriving mid-stall is deferred to the first IDLE cycle.
        next_cycle();
        exe_is_mul = 1;
        next_cycle();
        exe_is_mul = 0;
        #2 check("fl_busy_1", BUSY_V);
        next_cycle();
        flush_in = 1;
        #2 check("fl_busy_2_held", BUSY_V);
        next_cycle();
        flush_in = 0;
        #2 check("fl_busy_3_held", DONE_V);
        next_cycle(); #2 check("fl_released", FL_V);
        next_cycle(); #2 check("fl_single_pulse", 7'b0);

        // Reset mid-stall: immediate quiet outputs and the pending flush is dropped.
        next_cycle();
        exe_is_mul = 1;
        next_cycle();
        exe_is_mul = 0; flush_in = 1;
        #2 check("rst_busy_1", BUSY_V);
        next_cycle();
        flush_in = 0;
        #2 check("rst_busy_2", BUSY_V);
        rst = 1'b0;
        #1 check("rst_async_quiet", 7'b0);
        next_cycle();
        rst = 1'b1;
        #2 check("rst_release_idle", 7'b0);
        next_cycle(); #2 check("rst_no_flush", 7'b0);

        // Randomized traffic with occasional resets, judged by the model each cycle.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rand_inputs(1'b1);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(99) == 0) rst = 1'b0;
        end
        next_cycle();
        clr();
        rst = 1'b1;
        repeat (MC + 2) next_cycle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
